// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the E stage and the HI/LO multiply-divide unit.
// The pipeline side drives the master modport; mul_div_unit takes the slave modport.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        cancel;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs, rt, cancel,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, cancel,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Fixed-latency HI/LO multiply/divide unit: 5-cycle mult, 10-cycle div, commit on the 1->0 count edge.
// Define MDU_MADD_EN to enable MADD/MSUB (op 6/7); otherwise those opcodes are ignored.
module mul_div_unit (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  mdu
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        busy;
  logic        accept;
  logic        is_mul;
  logic        is_div;

  assign busy = (cnt_q != 4'd0);

  always_comb begin
    is_mul = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (mdu.op == OP_MADD) || (mdu.op == OP_MSUB);
`endif
    is_div = (mdu.op == OP_DIV) || (mdu.op == OP_DIVU);
  end

  assign accept        = mdu.start && !busy && !mdu.cancel;
  assign mdu.stall_req = busy || (mdu.start && (is_mul || is_div));
  assign mdu.busy      = busy;
  assign mdu.hi        = hi_q;
  assign mdu.lo        = lo_q;

  // Datapath works only from the latched operands, so rs/rt may change freely while busy.
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally as magnitude 0x80000000 with a positive sign.
  logic        div_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_b_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  assign div_signed = (op_q == OP_DIV);
  assign neg_a      = div_signed && a_q[31];
  assign neg_b      = div_signed && b_q[31];
  assign mag_a      = neg_a ? (~a_q + 32'd1) : a_q;
  assign mag_b      = neg_b ? (~b_q + 32'd1) : b_q;
  assign mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq         = mag_a / mag_b_safe;
  assign ur         = mag_a % mag_b_safe;
  assign quo        = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
  assign rem        = neg_a ? (~ur + 32'd1) : ur;

  logic [63:0] res;
  logic        commit_ok;

  always_comb begin
    res = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV,
      OP_DIVU:  res = {rem, quo};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MSUB:  res = {hi_q, lo_q} - prod_s;
`endif
      default:  res = {hi_q, lo_q};
    endcase
  end

  // A zero divisor still occupies the full divide latency but never writes HI/LO.
  assign commit_ok = !(((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'd0));

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (busy) begin
      if (mdu.cancel) begin
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
        if ((cnt_q == 4'd1) && commit_ok) begin
          hi_d = res[63:32];
          lo_d = res[31:0];
        end
      end
    end else if (accept) begin
      if (is_mul || is_div) begin
        cnt_d = is_div ? DIV_LAT : MUL_LAT;
        op_d  = mdu.op;
        a_d   = mdu.rs;
        b_d   = mdu.rt;
      end else if (mdu.op == OP_MTHI) begin
        hi_d = mdu.rs;
      end else if (mdu.op == OP_MTLO) begin
        lo_d = mdu.rs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: when high, op/rs/rt are valid this cycle.
REQ-004 The block SHALL have port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-005 The block SHALL have port rs, input, 32 bits: operand A, forwarded GPR value.
REQ-006 The block SHALL have port rt, input, 32 bits: operand B, forwarded GPR value.
REQ-007 The block SHALL have port cancel, input, 1 bit: exception/interrupt flush of the E-stage instruction.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-009 The block SHALL have port stall_req, output, 1 bit: the D stage must hold any HI/LO-using instruction.
REQ-010 The block SHALL have port hi, output, 32 bits: the architectural HI register.
REQ-011 The block SHALL have port lo, output, 32 bits: the architectural LO register.

Function
REQ-012 The block SHALL sample start only when busy=0 and cancel=0; start at any other time SHALL be ignored.
REQ-013 An accepted MULT/MULTU/MADD/MSUB SHALL load a 4-bit counter with 5; an accepted DIV/DIVU SHALL load it with 10.
REQ-014 busy SHALL equal (counter != 0), so it is high for exactly 5 (mult) or 10 (div) cycles after the accepting edge.
REQ-015 The counter SHALL decrement by 1 each edge while nonzero.
REQ-016 On the edge where the counter goes 1->0, the block SHALL commit the latched result to hi/lo.
REQ-017 The committed values SHALL be visible in the first cycle with busy=0.
REQ-018 Operands and op SHALL be latched at acceptance; later changes on rs/rt SHALL NOT affect the result.
REQ-019 MULT/MULTU SHALL produce the 64-bit signed/unsigned product {hi,lo}.
REQ-020 DIV/DIVU SHALL produce lo = quotient and hi = remainder.
REQ-021 Signed division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0.
REQ-023 For divisor 0, DIV/DIVU SHALL run the full 10 cycles and leave hi/lo unchanged.
REQ-024 MTHI/MTLO with start=1 SHALL write rs into hi/lo at the next edge, with no busy cycle.
REQ-025 stall_req SHALL equal busy OR (start AND op is a mult/div class op), combinationally.
REQ-026 cancel=1 while busy SHALL zero the counter at the next edge with no commit, so hi/lo keep their pre-operation values.
REQ-027 cancel=1 coincident with start SHALL suppress acceptance, including MTHI/MTLO.
REQ-028 If the commit edge coincides with cancel, cancel SHALL win and no commit SHALL occur.

Reset
REQ-029 When reset=1 at an edge, the block SHALL force hi=0, lo=0, counter=0, busy=0 and clear the latched operands.
REQ-030 reset SHALL take priority over start, cancel and commit; an in-flight operation SHALL be discarded.

Configuration
REQ-031 With macro MDU_MADD_EN defined, MADD SHALL commit {hi,lo} + signed(rs*rt) and MSUB SHALL commit {hi,lo} - signed(rs*rt), both with 5-cycle latency, modulo 2^64.
REQ-032 Without MDU_MADD_EN, op 6 and op 7 SHALL be treated as no-ops: not accepted, busy stays 0, and stall_req SHALL NOT be raised for them.

Verification
REQ-033 MULT rs=0xFFFFFFFE, rt=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 DIVU rs=7, rt=2 -> busy high for 10 cycles, then hi=1, lo=3; DIV rs=0xFFFFFFF9 (-7), rt=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-035 MTHI rs=0x12345678 -> hi=0x12345678 the next cycle, busy stays 0; DIV by 0 afterwards -> hi still 0x12345678 after 10 cycles.
REQ-036 MULT 2*3, with cancel pulsed in busy cycle 3 -> busy low the next cycle and hi/lo unchanged; a second start during busy -> ignored.
REQ-037 Reset asserted in the middle of a DIV -> busy=0, hi=lo=0 next cycle; no commit ten cycles later.
REQ-038 With MDU_MADD_EN defined, hi=0, lo=10, then MADD 2*3 -> lo=16; without the macro, op 6 -> hi/lo unchanged and busy=0.
